// File: rtl/rename_rat.sv
// Register alias table for the rename stage: looks up producer ROB tags for rs1/rs2,
// allocates the ROB tail as the rd tag and presents a registered result to dispatch.
module rename_rat #(
    parameter int NUM_REGS      = 32,
    parameter int ROB_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    input  logic [4:0]               dec_rs1_addr,
    input  logic [4:0]               dec_rs2_addr,
    input  logic [4:0]               dec_rd_addr,
    input  logic                     dec_regf_we,
    output logic                     dec_ready,
    input  logic [ROB_IDX_WIDTH-1:0] rob_tail_idx,
    input  logic                     rob_full,
    output logic                     rob_alloc,
    output logic                     dis_valid,
    input  logic                     dis_accept,
    output logic [ROB_IDX_WIDTH-1:0] dis_rd_rob_idx,
    output logic [ROB_IDX_WIDTH-1:0] dis_rs1_rob_idx,
    output logic [ROB_IDX_WIDTH-1:0] dis_rs2_rob_idx,
    output logic                     dis_rs1_ready,
    output logic                     dis_rs2_ready,
    input  logic                     commit_valid,
    input  logic [4:0]               commit_rd_addr,
    input  logic [ROB_IDX_WIDTH-1:0] commit_rob_idx,
    input  logic                     flush
);

    logic                     busy [NUM_REGS];
    logic [ROB_IDX_WIDTH-1:0] tag  [NUM_REGS];

    logic                     out_adv;
    logic                     fire;
    logic                     ren_we;
    logic                     cmt_clr;
    logic                     rs1_ready;
    logic                     rs2_ready;
    logic [ROB_IDX_WIDTH-1:0] rs1_tag;
    logic [ROB_IDX_WIDTH-1:0] rs2_tag;

    // Handshakes: a transfer happens on a cycle where valid & ready are both high;
    // valid never depends on ready, and a presented dis_* result holds until accepted.
    assign out_adv   = !dis_valid || dis_accept;
    assign dec_ready = rst && !flush && !rob_full && out_adv;
    assign fire      = dec_valid && dec_ready;
    assign rob_alloc = fire;

    // Lookups read the table before this edge's writes, so rs == rd sees the old mapping.
    assign rs1_ready = !busy[dec_rs1_addr] || (dec_rs1_addr == 5'd0);
    assign rs2_ready = !busy[dec_rs2_addr] || (dec_rs2_addr == 5'd0);
    assign rs1_tag   = rs1_ready ? '0 : tag[dec_rs1_addr];
    assign rs2_tag   = rs2_ready ? '0 : tag[dec_rs2_addr];

    assign ren_we  = fire && dec_regf_we && (dec_rd_addr != 5'd0);
    assign cmt_clr = commit_valid && (commit_rd_addr != 5'd0) && busy[commit_rd_addr]
                     && (tag[commit_rd_addr] == commit_rob_idx);

    // A rename to the same register as a commit wins, keeping the entry busy with the new tag.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rst || flush) begin
                busy[i] <= 1'b0;
                tag[i]  <= '0;
            end else if (ren_we && (dec_rd_addr == 5'(i))) begin
                busy[i] <= 1'b1;
                tag[i]  <= rob_tail_idx;
            end else if (cmt_clr && (commit_rd_addr == 5'(i))) begin
                busy[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            dis_valid       <= 1'b0;
            dis_rd_rob_idx  <= '0;
            dis_rs1_rob_idx <= '0;
            dis_rs2_rob_idx <= '0;
            dis_rs1_ready   <= 1'b0;
            dis_rs2_ready   <= 1'b0;
        end else if (out_adv) begin
            dis_valid <= fire;
            if (fire) begin
                dis_rd_rob_idx  <= rob_tail_idx;
                dis_rs1_rob_idx <= rs1_tag;
                dis_rs2_rob_idx <= rs2_tag;
                dis_rs1_ready   <= rs1_ready;
                dis_rs2_ready   <= rs2_ready;
            end
        end
    end

endmodule

// File: tb/tb_rename_rat.sv
// Bench for rename_rat: a reference alias-table model predicts each rename result,
// pushes it on an expected queue at fire, and pops it when dispatch sees a new result.
module tb_rename_rat;

    localparam int W  = 5;
    localparam int PW = 3 * W + 2;

    logic         clk;
    logic         rst;
    logic         dec_valid;
    logic [4:0]   dec_rs1_addr;
    logic [4:0]   dec_rs2_addr;
    logic [4:0]   dec_rd_addr;
    logic         dec_regf_we;
    logic         dec_ready;
    logic [W-1:0] rob_tail_idx;
    logic         rob_full;
    logic         rob_alloc;
    logic         dis_valid;
    logic         dis_accept;
    logic [W-1:0] dis_rd_rob_idx;
    logic [W-1:0] dis_rs1_rob_idx;
    logic [W-1:0] dis_rs2_rob_idx;
    logic         dis_rs1_ready;
    logic         dis_rs2_ready;
    logic         commit_valid;
    logic [4:0]   commit_rd_addr;
    logic [W-1:0] commit_rob_idx;
    logic         flush;

    rename_rat #(.NUM_REGS(32), .ROB_IDX_WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .dec_valid       (dec_valid),
        .dec_rs1_addr    (dec_rs1_addr),
        .dec_rs2_addr    (dec_rs2_addr),
        .dec_rd_addr     (dec_rd_addr),
        .dec_regf_we     (dec_regf_we),
        .dec_ready       (dec_ready),
        .rob_tail_idx    (rob_tail_idx),
        .rob_full        (rob_full),
        .rob_alloc       (rob_alloc),
        .dis_valid       (dis_valid),
        .dis_accept      (dis_accept),
        .dis_rd_rob_idx  (dis_rd_rob_idx),
        .dis_rs1_rob_idx (dis_rs1_rob_idx),
        .dis_rs2_rob_idx (dis_rs2_rob_idx),
        .dis_rs1_ready   (dis_rs1_ready),
        .dis_rs2_ready   (dis_rs2_ready),
        .commit_valid    (commit_valid),
        .commit_rd_addr  (commit_rd_addr),
        .commit_rob_idx  (commit_rob_idx),
        .flush           (flush)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] last_exp;
    logic          busy_m [32];
    logic [W-1:0]  tag_m  [32];
    logic          exp_dv;
    int            n_checks;
    int            n_errors;

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            busy_m[i] = 1'b0;
            tag_m[i]  = '0;
        end
        exp_dv = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, update model, check after edge.
    task automatic step(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic [W-1:0] tail,
                        input logic full, input logic acc, input logic cv,
                        input logic [4:0] crd, input logic [W-1:0] cidx, input logic fl);
        logic          m_ready, m_fire, r1, r2, prev_dv, fresh_ok, hold;
        logic [W-1:0]  t1, t2;
        logic [PW-1:0] obs;
        @(negedge clk);
        dec_valid      = dv;
        dec_rs1_addr   = rs1;
        dec_rs2_addr   = rs2;
        dec_rd_addr    = rd;
        dec_regf_we    = we;
        rob_tail_idx   = tail;
        rob_full       = full;
        dis_accept     = acc;
        commit_valid   = cv;
        commit_rd_addr = crd;
        commit_rob_idx = cidx;
        flush          = fl;
        #1;
        m_ready = rst && !fl && !full && (!exp_dv || acc);
        m_fire  = dv && m_ready;
        check_eq("dec_ready", dec_ready, m_ready);
        check_eq("rob_alloc", rob_alloc, m_fire);
        if (m_fire) begin
            r1 = !busy_m[rs1] || (rs1 == 5'd0);
            r2 = !busy_m[rs2] || (rs2 == 5'd0);
            t1 = r1 ? '0 : tag_m[rs1];
            t2 = r2 ? '0 : tag_m[rs2];
            exp_q.push_back({tail, t1, t2, r1, r2});
        end
        prev_dv  = dis_valid;
        fresh_ok = rst && !fl && (!prev_dv || acc);
        hold     = rst && !fl && prev_dv && !acc;
        if (!rst || fl) begin
            model_clear();
        end else begin
            if (!exp_dv || acc) exp_dv = m_fire;
            if (cv && crd != 5'd0 && busy_m[crd] && tag_m[crd] == cidx) busy_m[crd] = 1'b0;
            if (m_fire && we && rd != 5'd0) begin
                busy_m[rd] = 1'b1;
                tag_m[rd]  = tail;
            end
        end
        @(posedge clk);
        #1;
        check_eq("dis_valid", dis_valid, exp_dv);
        obs = {dis_rd_rob_idx, dis_rs1_rob_idx, dis_rs2_rob_idx, dis_rs1_ready, dis_rs2_ready};
        if (dis_valid && fresh_ok) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_result", dis_valid, 1'b0);
            end else begin
                last_exp = exp_q.pop_front();
                check_eq("dis_result", obs, last_exp);
            end
        end
        if (hold && dis_valid) check_eq("hold_stable", obs, last_exp);
    endtask

    // driver shorthands
    task automatic ren(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [W-1:0] tail);
        step(1'b1, rs1, rs2, rd, 1'b1, tail, 1'b0, 1'b1, 1'b0, 5'd0, '0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 1'b0);
    endtask

    task automatic commit(input logic [4:0] crd, input logic [W-1:0] cidx);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b0, 1'b1, 1'b1, crd, cidx, 1'b0);
    endtask

    initial begin
        logic [W-1:0] tail_c;
        logic [4:0]   rrs1, rrs2, rrd, rcrd;
        logic [W-1:0] rcidx;
        logic         rdv, racc, rfull, rcv, rfl;

        n_checks = 0;
        n_errors = 0;
        last_exp = '0;
        model_clear();
        rst = 1'b0;
        dec_valid = 1'b0; dec_rs1_addr = '0; dec_rs2_addr = '0; dec_rd_addr = '0;
        dec_regf_we = 1'b0; rob_tail_idx = '0; rob_full = 1'b0; dis_accept = 1'b1;
        commit_valid = 1'b0; commit_rd_addr = '0; commit_rob_idx = '0; flush = 1'b0;

        // reset with a pending decode: no allocation while rst is low
        for (int i = 0; i < 3; i++) ren(5'd5, 5'd1, 5'd2, 5'd9);
        check_eq("rst_rd_tag", dis_rd_rob_idx, 5'd0);
        check_eq("rst_rs1_tag", dis_rs1_rob_idx, 5'd0);
        check_eq("rst_rs2_tag", dis_rs2_rob_idx, 5'd0);
        check_eq("rst_rs1_ready", dis_rs1_ready, 1'b0);
        check_eq("rst_rs2_ready", dis_rs2_ready, 1'b0);
        rst = 1'b1;
        idle();

        // basic rename and dependent lookup
        ren(5'd5, 5'd0, 5'd0, 5'd3);
        check_eq("tp1_rd_tag", dis_rd_rob_idx, 5'd3);
        check_eq("tp1_ready", {dis_rs1_ready, dis_rs2_ready}, 2'b11);
        ren(5'd6, 5'd5, 5'd0, 5'd4);
        check_eq("tp1_rs1_tag", dis_rs1_rob_idx, 5'd3);
        check_eq("tp1_rs1_ready", dis_rs1_ready, 1'b0);

        // rs1 == rd sees the older mapping
        ren(5'd7, 5'd7, 5'd0, 5'd2);
        check_eq("tp2_rs1_ready", dis_rs1_ready, 1'b1);
        ren(5'd0, 5'd7, 5'd0, 5'd11);
        check_eq("tp2_rs1_tag", dis_rs1_rob_idx, 5'd2);
        check_eq("tp2_rs1_busy", dis_rs1_ready, 1'b0);

        // stale commit leaves a renamed entry busy
        ren(5'd9, 5'd0, 5'd0, 5'd6);
        ren(5'd9, 5'd0, 5'd0, 5'd8);
        commit(5'd9, 5'd6);
        ren(5'd0, 5'd9, 5'd0, 5'd12);
        check_eq("tp3_stale_tag", dis_rs1_rob_idx, 5'd8);
        check_eq("tp3_stale_ready", dis_rs1_ready, 1'b0);
        commit(5'd9, 5'd8);
        ren(5'd0, 5'd9, 5'd0, 5'd13);
        check_eq("tp3_commit_ready", dis_rs1_ready, 1'b1);

        // same-cycle commit and rename of x4: rename wins
        ren(5'd4, 5'd0, 5'd0, 5'd1);
        step(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 5'd10, 1'b0, 1'b1, 1'b1, 5'd4, 5'd1, 1'b0);
        ren(5'd0, 5'd4, 5'd0, 5'd14);
        check_eq("tp4_tag", dis_rs1_rob_idx, 5'd10);
        check_eq("tp4_ready", dis_rs1_ready, 1'b0);

        // hold with dispatch stalled, then rob_full with dispatch draining
        idle();
        step(1'b1, 5'd1, 5'd9, 5'd20, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd4, 5'd20, 5'd21, 1'b1, 5'd16, 1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0);
        check_eq("tp5_hold_rd", dis_rd_rob_idx, 5'd15);
        step(1'b1, 5'd4, 5'd20, 5'd21, 1'b1, 5'd16, 1'b1, 1'b1, 1'b0, 5'd0, '0, 1'b0);
        idle();

        // flush clears table and output register
        ren(5'd1, 5'd0, 5'd0, 5'd16);
        ren(5'd2, 5'd0, 5'd0, 5'd17);
        ren(5'd3, 5'd0, 5'd0, 5'd18);
        step(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 5'd19, 1'b0, 1'b1, 1'b0, 5'd0, '0, 1'b1);
        check_eq("tp6_flush_dv", dis_valid, 1'b0);
        ren(5'd0, 5'd1, 5'd2, 5'd20);
        check_eq("tp6_x1x2_ready", {dis_rs1_ready, dis_rs2_ready}, 2'b11);
        ren(5'd0, 5'd3, 5'd0, 5'd21);
        check_eq("tp6_x3_ready", dis_rs1_ready, 1'b1);

        // randomized traffic against the model
        tail_c = 5'd0;
        for (int i = 0; i < 400; i++) begin
            rdv   = ($urandom_range(0, 3) != 0);
            rrs1  = 5'($urandom_range(0, 7));
            rrs2  = 5'($urandom_range(0, 7));
            rrd   = 5'($urandom_range(0, 7));
            racc  = ($urandom_range(0, 3) != 0);
            rfull = ($urandom_range(0, 7) == 0);
            rcv   = ($urandom_range(0, 1) == 1);
            rcrd  = 5'($urandom_range(0, 7));
            rcidx = ($urandom_range(0, 1) == 1) ? tag_m[rcrd] : 5'($urandom_range(0, 31));
            rfl   = ($urandom_range(0, 39) == 0);
            step(rdv, rrs1, rrs2, rrd, ($urandom_range(0, 3) != 0), tail_c, rfull, racc,
                 rcv, rcrd, rcidx, rfl);
            tail_c = tail_c + 5'd1;
        end
        idle();

        // reset mid-stream wins over fire and commit
        ren(5'd8, 5'd0, 5'd0, 5'd22);
        rst = 1'b0;
        step(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 5'd23, 1'b0, 1'b1, 1'b1, 5'd8, 5'd22, 1'b0);
        check_eq("midrst_dv", dis_valid, 1'b0);
        rst = 1'b1;
        ren(5'd0, 5'd8, 5'd0, 5'd24);
        check_eq("midrst_x8_ready", dis_rs1_ready, 1'b1);
        idle();

        check_eq("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
